// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice: state encoding,
// default widths and the opcode values the command sources use.
package alu_arbiter_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = NB_DATA_DEF - 2;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_EXEC = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side bundle of the arbiter. The arbiter is the slave;
// the requesters plus the ALU together form the master side.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int N_REQ   = 2
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*NB_DATA-1:0] req_a;
  logic [N_REQ*NB_DATA-1:0] req_b;
  logic [N_REQ*NB_OP-1:0]   req_op;
  logic [N_REQ-1:0]         ack;
  logic [NB_DATA-1:0]       result;
  logic                     err;
  logic                     busy;
  logic                     alu_start;
  logic [NB_DATA-1:0]       alu_a;
  logic [NB_DATA-1:0]       alu_b;
  logic [NB_OP-1:0]         alu_op;
  logic [NB_DATA-1:0]       alu_result;
  logic                     alu_valid;

  modport slave (
    input  req, req_a, req_b, req_op, alu_result, alu_valid,
    output ack, result, err, busy, alu_start, alu_a, alu_b, alu_op
  );

  modport master (
    output req, req_a, req_b, req_op, alu_result, alu_valid,
    input  ack, result, err, busy, alu_start, alu_a, alu_b, alu_op
  );

endinterface

// File: rtl/alu_arbiter_rr_select.sv
// Combinational round-robin pick: first asserted request strictly after
// last_grant, wrapping modulo N_REQ.
module rr_select
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDXW  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last_grant,
  output logic [IDXW-1:0]  grant_idx,
  output logic             any_req
);

  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= N_REQ) ? (sum - N_REQ) : sum;
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest asserted one wins.
  always_comb begin
    grant_idx = {IDXW{1'b0}};
    any_req   = |req;
    for (int off = N_REQ; off >= 1; off--) begin
      grant_idx = req[wrap_idx(int'(last_grant), off)] ?
                  IDXW'(wrap_idx(int'(last_grant), off)) : grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin grant, operand latch,
// start/valid handshake with a watchdog, and a one-cycle ack back.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  localparam int IDXW = idx_width(N_REQ);
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             state_r, state_next_s;
  logic [IDXW-1:0]    grant_r, grant_next_s;
  logic [IDXW-1:0]    last_grant_r, last_grant_next_s;
  logic [IDXW-1:0]    sel_idx_s;
  logic               any_req_s;
  logic [NB_DATA-1:0] a_r, a_next_s;
  logic [NB_DATA-1:0] b_r, b_next_s;
  logic [NB_OP-1:0]   op_r, op_next_s;
  logic [CNTW-1:0]    cnt_r, cnt_next_s;
  logic [N_REQ-1:0]   ack_r, ack_next_s;
  logic [NB_DATA-1:0] result_r, result_next_s;
  logic               err_r, err_next_s;
  logic               busy_r;
  logic               start_r;

  rr_select #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_select (
    .req        (bus.req),
    .last_grant (last_grant_r),
    .grant_idx  (sel_idx_s),
    .any_req    (any_req_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_next_s      = state_r;
    grant_next_s      = grant_r;
    last_grant_next_s = last_grant_r;
    a_next_s          = a_r;
    b_next_s          = b_r;
    op_next_s         = op_r;
    cnt_next_s        = cnt_r;
    ack_next_s        = {N_REQ{1'b0}};
    result_next_s     = {NB_DATA{1'b0}};
    err_next_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_next_s = sel_idx_s;
          a_next_s     = bus.req_a[int'(sel_idx_s)*NB_DATA +: NB_DATA];
          b_next_s     = bus.req_b[int'(sel_idx_s)*NB_DATA +: NB_DATA];
          op_next_s    = bus.req_op[int'(sel_idx_s)*NB_OP +: NB_OP];
          cnt_next_s   = {CNTW{1'b0}};
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        cnt_next_s = cnt_r + CNTW'(1);
        // A completion on the watchdog's last cycle still counts as success.
        if (bus.alu_valid) begin
          result_next_s = bus.alu_result;
          err_next_s    = 1'b0;
          ack_next_s    = ONE_LSB << grant_r;
          state_next_s  = DONE;
        end else if (cnt_r == CNTW'(TIMEOUT - 1)) begin
          result_next_s = {NB_DATA{1'b0}};
          err_next_s    = 1'b1;
          ack_next_s    = ONE_LSB << grant_r;
          state_next_s  = DONE;
        end else begin
          state_next_s = EXEC;
        end
      end
      DONE: begin
        last_grant_next_s = grant_r;
        cnt_next_s        = {CNTW{1'b0}};
        state_next_s      = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r      <= {IDXW{1'b0}};
      last_grant_r <= IDXW'(N_REQ - 1);
      a_r          <= {NB_DATA{1'b0}};
      b_r          <= {NB_DATA{1'b0}};
      op_r         <= {NB_OP{1'b0}};
      cnt_r        <= {CNTW{1'b0}};
      ack_r        <= {N_REQ{1'b0}};
      result_r     <= {NB_DATA{1'b0}};
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      start_r      <= 1'b0;
    end else begin
      grant_r      <= grant_next_s;
      last_grant_r <= last_grant_next_s;
      a_r          <= a_next_s;
      b_r          <= b_next_s;
      op_r         <= op_next_s;
      cnt_r        <= cnt_next_s;
      ack_r        <= ack_next_s;
      result_r     <= result_next_s;
      err_r        <= err_next_s;
      busy_r       <= (state_next_s != IDLE);
      start_r      <= (state_next_s == EXEC);
    end
  end

  assign bus.ack       = ack_r;
  assign bus.result    = result_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
  assign bus.alu_start = start_r;
  assign bus.alu_a     = a_r;
  assign bus.alu_b     = b_r;
  assign bus.alu_op    = op_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked
// every cycle against a transaction-level reference of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;

  alu_arbiter_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_REQ(N_REQ)) bus ();

  alu_arbiter #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP),
    .N_REQ   (N_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: who owns the ALU, how long it has run, what it will return.
  int               m_owner;
  int               m_last;
  int               m_exec_n;
  bit               m_done;
  bit               m_err;
  logic [NB_DATA-1:0] m_a, m_b, m_res;
  logic [NB_OP-1:0]   m_op;

  // ALU / traffic knobs: delay_cfg >0 fixed, 0 random, <0 never completes.
  int alu_cyc   = 0;
  int alu_delay = 0;
  int delay_cfg = 2;
  bit spur_en   = 1'b0;
  bit rand_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NB_DATA-1:0] alu_fn(input logic [NB_DATA-1:0] a,
                                                input logic [NB_DATA-1:0] b,
                                                input logic [NB_OP-1:0]   op);
    if (op == OP_ADD) return a + b;
    else if (op == OP_SUB) return a - b;
    else return a & b;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_owner = -1; m_last = N_REQ - 1; m_exec_n = 0; m_done = 1'b0; m_err = 1'b0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (m_owner < 0 && bus.req[(m_last + k) % N_REQ]) m_owner = (m_last + k) % N_REQ;
      end
      if (m_owner >= 0) begin
        m_a = bus.req_a[m_owner*NB_DATA +: NB_DATA];
        m_b = bus.req_b[m_owner*NB_DATA +: NB_DATA];
        m_op = bus.req_op[m_owner*NB_OP +: NB_OP];
        m_exec_n = 1;
      end
    end else if (!m_done) begin
      if (bus.alu_valid) begin
        m_done = 1'b1; m_err = 1'b0; m_res = alu_fn(m_a, m_b, m_op);
      end else if (m_exec_n == TIMEOUT) begin
        m_done = 1'b1; m_err = 1'b1; m_res = '0;
      end else begin
        m_exec_n++;
      end
    end else begin
      m_last = m_owner; m_owner = -1; m_done = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit acking;
    acking = m_done && (m_owner >= 0);
    check_eq("ack", bus.ack, acking ? (32'd1 << m_owner) : 32'd0);
    check_eq("result", bus.result, acking ? m_res : 8'h00);
    check_eq("err", bus.err, acking && m_err);
    check_eq("busy", bus.busy, m_owner >= 0);
    check_eq("alu_start", bus.alu_start, (m_owner >= 0) && !m_done);
    check_eq("alu_a", bus.alu_a, m_a);
    check_eq("alu_b", bus.alu_b, m_b);
    check_eq("alu_op", bus.alu_op, m_op);
  endtask

  task automatic alu_drive();
    if (bus.alu_start) begin
      alu_cyc++;
      if (alu_cyc == 1) begin
        if (delay_cfg > 0) alu_delay = delay_cfg;
        else if (delay_cfg < 0) alu_delay = 0;
        else alu_delay = ($urandom % 16 == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 2));
      end
      bus.alu_valid = (alu_delay != 0) && (alu_cyc == alu_delay);
    end else begin
      alu_cyc = 0;
      bus.alu_valid = spur_en || (rand_mode && ($urandom % 8 == 0));
    end
    bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
  endtask

  task automatic set_req(input int i, input bit lvl, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] op);
    bus.req[i] = lvl;
    bus.req_a[i*NB_DATA +: NB_DATA] = a;
    bus.req_b[i*NB_DATA +: NB_DATA] = b;
    bus.req_op[i*NB_OP +: NB_OP] = op;
  endtask

  task automatic new_op(input int i);
    logic [5:0] op;
    case ($urandom % 3)
      0: op = OP_ADD;
      1: op = OP_SUB;
      default: op = 6'($urandom);
    endcase
    set_req(i, 1'b1, 8'($urandom), 8'($urandom), op);
  endtask

  task automatic agent_drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (m_done && m_owner == i) begin
        if ($urandom % 2 == 0) new_op(i);
        else bus.req[i] = 1'b0;
      end else if (!bus.req[i]) begin
        if ($urandom % 4 == 0) new_op(i);
      end else if (m_owner != i && $urandom % 16 == 0) begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    alu_drive();
    if (rand_mode) agent_drive();
  endtask

  task automatic run_until_ack(input int bound, output int idx, output logic [7:0] res,
                               output logic e, output int starts);
    idx = -1; res = '0; e = 1'b0; starts = 0;
    for (int n = 0; n < bound; n++) begin
      tick();
      if (bus.alu_start) starts++;
      if (|bus.ack) begin
        idx = bus.ack[1] ? 1 : 0;
        res = bus.result;
        e = bus.err;
        break;
      end
    end
    check_eq("ack_seen", idx >= 0, 1);
  endtask

  int idx, prev, st;
  logic [7:0] res;
  logic e;

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
    bus.alu_valid = 1'b0; bus.alu_result = '0;
    tick(); tick();
    reset = 1'b0;

    // Single request, ALU answers on its second start cycle.
    delay_cfg = 2;
    set_req(0, 1'b1, 8'h05, 8'h03, OP_ADD);
    run_until_ack(20, idx, res, e, st);
    check_eq("t1_idx", idx, 0); check_eq("t1_res", res, 8'h08);
    check_eq("t1_err", e, 0); check_eq("t1_starts", st, 2);
    bus.req[0] = 1'b0;
    tick();
    check_eq("t1_busy_after", bus.busy, 0);

    // Simultaneous requests right after reset.
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(0, 1'b1, 8'd10, 8'd4, OP_SUB);
    set_req(1, 1'b1, 8'd1, 8'd1, OP_ADD);
    run_until_ack(20, idx, res, e, st);
    check_eq("t2_first_idx", idx, 0); check_eq("t2_first_res", res, 8'd6);
    bus.req[0] = 1'b0;
    run_until_ack(20, idx, res, e, st);
    check_eq("t2_second_idx", idx, 1); check_eq("t2_second_res", res, 8'd2);
    bus.req[1] = 1'b0;
    tick();

    // Continuous contention alternates 0,1,0,1,...
    set_req(0, 1'b1, 8'd20, 8'd5, OP_ADD);
    set_req(1, 1'b1, 8'd20, 8'd5, OP_SUB);
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      run_until_ack(20, idx, res, e, st);
      check_eq("t3_seq", idx, k % 2);
      if (k > 0) check_eq("t3_alternate", idx != prev, 1);
      prev = idx;
    end
    bus.req = '0;
    tick();

    // Watchdog abort, then a normal op, then valid on the last watchdog cycle.
    delay_cfg = -1;
    set_req(0, 1'b1, 8'h12, 8'h34, OP_ADD);
    run_until_ack(TIMEOUT + 10, idx, res, e, st);
    check_eq("t4_to_err", e, 1); check_eq("t4_to_res", res, 8'h00);
    check_eq("t4_to_starts", st, TIMEOUT);
    delay_cfg = 2;
    set_req(0, 1'b1, 8'd7, 8'd2, OP_SUB);
    run_until_ack(20, idx, res, e, st);
    check_eq("t4_next_err", e, 0); check_eq("t4_next_res", res, 8'd5);
    delay_cfg = TIMEOUT;
    set_req(0, 1'b1, 8'd200, 8'd100, OP_ADD);
    run_until_ack(TIMEOUT + 10, idx, res, e, st);
    check_eq("t4_edge_err", e, 0); check_eq("t4_edge_res", res, 8'h2C);
    check_eq("t4_edge_starts", st, TIMEOUT);
    bus.req[0] = 1'b0;
    tick();

    // Reset during the third EXEC cycle, request still held.
    delay_cfg = 10;
    set_req(0, 1'b1, 8'd9, 8'd1, OP_ADD);
    for (int n = 0; n < 20; n++) begin
      if (alu_cyc >= 3) break;
      tick();
    end
    check_eq("t5_exec3", alu_cyc, 3);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("t5_busy", bus.busy, 0); check_eq("t5_ack", bus.ack, 0);
    check_eq("t5_start", bus.alu_start, 0);
    delay_cfg = 2;
    run_until_ack(20, idx, res, e, st);
    check_eq("t5_regrant_idx", idx, 0); check_eq("t5_regrant_res", res, 8'd10);
    bus.req[0] = 1'b0;
    tick();

    // Stray alu_valid while idle.
    spur_en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      check_eq("t6_busy", bus.busy, 0); check_eq("t6_result", bus.result, 0);
    end
    spur_en = 1'b0;

    // Random traffic.
    delay_cfg = 0;
    rand_mode = 1'b1;
    repeat (1500) tick();
    rand_mode = 1'b0;
    bus.req = '0;
    repeat (TIMEOUT + 6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
